// File: rtl/count_scan_ctrl.sv
// rtl/count_scan_ctrl.sv - loadable 0..15 countdown with pause/resume and two-digit 7-segment display
module count_scan_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] value,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    st_idle,
    st_ready,
    st_run,
    st_hold,
    st_done
  } state_t;

  state_t        state, state_n;
  logic [3:0]    value_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    tens_n, units_n;
  logic [6:0]    hex1_n, hex0_n;

  // Active-low segments, bit6=g .. bit0=a
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    value_n = value;
    presc_n = presc;
    case (state)
      st_idle, st_ready, st_done: begin
        if (load) begin
          value_n = sw;
          presc_n = '0;
          state_n = st_ready;
        end else if (state == st_ready && start) begin
          presc_n = '0;
          state_n = (value != 4'd0) ? st_run : st_done;
        end
      end
      st_run: begin
        // Pause wins over a coincident step: nothing moves this cycle
        if (pause) begin
          state_n = st_hold;
        end else if (presc == PRESC_LAST) begin
          presc_n = '0;
          if (value <= 4'd1) begin
            value_n = 4'd0;
            state_n = st_done;
          end else begin
            value_n = value - 4'd1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      st_hold: begin
        if (start && !pause) state_n = st_run;
      end
      default: state_n = st_idle;
    endcase
  end

  // Display decodes the next value so the registered segments never lag value
  always_comb begin
    tens_n  = (value_n > 4'd9) ? 4'd1 : 4'd0;
    units_n = (value_n > 4'd9) ? value_n - 4'd10 : value_n;
    hex1_n  = (state_n == st_idle) ? SEG_BLANK : seg7(tens_n);
    hex0_n  = (state_n == st_idle) ? SEG_BLANK : seg7(units_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
      value <= 4'd0;
      presc <= '0;
      hex1  <= SEG_BLANK;
      hex0  <= SEG_BLANK;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      value <= value_n;
      presc <= presc_n;
      hex1  <= hex1_n;
      hex0  <= hex0_n;
      busy  <= (state_n == st_run) || (state_n == st_hold);
      done  <= (state_n == st_done);
    end
  end

endmodule
